histo_frame_arbiter: RTL and testbench

//  Two-source frame scheduler sharing one histogram_calc engine. Grants one AXI-stream source for a whole frame,

---
 rtl/histo_frame_arbiter.sv | 150 +++++++++++++++
 tb/tb_histo_frame_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/histo_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : histo_frame_arbiter
//  Brief    : Round-robin, frame-granular scheduler that lets two AXI-stream
//             pixel sources share one histogram engine. Optional per-source
//             frame counters are enabled by defining HISTO_ARB_STATS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module histo_frame_arbiter #(
    parameter int P_DW        = 2,
    parameter int P_MAX_BEATS = 256,
    parameter int P_CNT_W     = 16
) (
    input  logic            aclk,
    input  logic            areset_n,
    input  logic [P_DW-1:0] s0_tdata,
    input  logic            s0_tvalid,
    input  logic            s0_tlast,
    output logic            s0_tready,
    input  logic [P_DW-1:0] s1_tdata,
    input  logic            s1_tvalid,
    input  logic            s1_tlast,
    output logic            s1_tready,
    output logic [P_DW-1:0] histo_data_i,
    output logic            rx_valid,
    output logic            rx_done,
    input  logic            histo_ready,
    input  logic            histo_data_valid,
    input  logic            histo_data_last,
    input  logic            tready,
    output logic            result_src,
    output logic            busy
`ifdef HISTO_ARB_STATS_EN
    ,
    output logic [P_CNT_W-1:0] frames0_o,
    output logic [P_CNT_W-1:0] frames1_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    localparam logic [P_CNT_W-1:0] C_MAX_BEATS = P_CNT_W'(P_MAX_BEATS);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_rr_ptr;
    logic               w_rr_nxt;
    logic               r_src;
    logic               w_src_nxt;
    logic [P_CNT_W-1:0] r_beat_cnt;
    logic [P_CNT_W-1:0] w_beat_cnt_nxt;
    logic [P_CNT_W-1:0] w_beat_inc;
    logic               w_gnt_valid;
    logic               w_gnt_last;
    logic [P_DW-1:0]    w_gnt_data;
    logic               w_accept;

    assign w_gnt_valid = r_src ? s1_tvalid : s0_tvalid;
    assign w_gnt_last  = r_src ? s1_tlast  : s0_tlast;
    assign w_gnt_data  = r_src ? s1_tdata  : s0_tdata;
    assign w_beat_inc  = r_beat_cnt + P_CNT_W'(1);
    assign w_accept    = (r_state == S_STREAM) && w_gnt_valid && histo_ready;

    assign result_src = r_src;
    assign busy       = (r_state != S_IDLE);

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= 1'b0;
            r_src      <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_src      <= w_src_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    // Ready depends only on state and histo_ready, never on a source's tvalid.
    always_comb begin
        w_state_nxt    = r_state;
        w_rr_nxt       = r_rr_ptr;
        w_src_nxt      = r_src;
        w_beat_cnt_nxt = r_beat_cnt;
        s0_tready      = 1'b0;
        s1_tready      = 1'b0;
        histo_data_i   = '0;
        rx_valid       = 1'b0;
        rx_done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (s0_tvalid || s1_tvalid) begin
                    w_src_nxt   = (s0_tvalid && s1_tvalid) ? r_rr_ptr : s1_tvalid;
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                rx_valid     = w_gnt_valid;
                histo_data_i = w_gnt_data;
                if (r_src) s1_tready = histo_ready;
                else       s0_tready = histo_ready;
                if (w_accept) begin
                    w_beat_cnt_nxt = w_beat_inc;
                    if (w_gnt_last || (w_beat_inc == C_MAX_BEATS))
                        w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                rx_done        = 1'b1;
                w_beat_cnt_nxt = '0;
                w_state_nxt    = S_DRAIN;
            end
            S_DRAIN: begin
                // Engine result burst is complete only on its accepted last bin.
                if (histo_data_valid && histo_data_last && tready) begin
                    w_state_nxt = S_IDLE;
                    w_rr_nxt    = ~r_src;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef HISTO_ARB_STATS_EN
    logic [P_CNT_W-1:0] r_frames0;
    logic [P_CNT_W-1:0] r_frames1;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_frames0 <= '0;
            r_frames1 <= '0;
        end else if (r_state == S_DONE) begin
            if (r_src) r_frames1 <= r_frames1 + P_CNT_W'(1);
            else       r_frames0 <= r_frames0 + P_CNT_W'(1);
        end
    end

    assign frames0_o = r_frames0;
    assign frames1_o = r_frames1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_histo_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_histo_frame_arbiter
//  Brief    : Directed self-checking bench for histo_frame_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_histo_frame_arbiter;

    localparam int P_DW        = 2;
    localparam int P_MAX_BEATS = 8;
    localparam int P_CNT_W     = 16;

    logic            aclk = 1'b0;
    logic            areset_n;
    logic [P_DW-1:0] s0_tdata, s1_tdata;
    logic            s0_tvalid, s0_tlast, s0_tready;
    logic            s1_tvalid, s1_tlast, s1_tready;
    logic [P_DW-1:0] histo_data_i;
    logic            rx_valid, rx_done, histo_ready;
    logic            histo_data_valid, histo_data_last, tready;
    logic            result_src, busy;
`ifdef HISTO_ARB_STATS_EN
    logic [P_CNT_W-1:0] frames0_o, frames1_o;
`endif

    int errors = 0;
    int checks = 0;

    always #5 aclk = ~aclk;

    histo_frame_arbiter #(
        .P_DW(P_DW), .P_MAX_BEATS(P_MAX_BEATS), .P_CNT_W(P_CNT_W)
    ) dut (
        .aclk(aclk), .areset_n(areset_n),
        .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
        .histo_data_i(histo_data_i), .rx_valid(rx_valid), .rx_done(rx_done),
        .histo_ready(histo_ready), .histo_data_valid(histo_data_valid),
        .histo_data_last(histo_data_last), .tready(tready),
        .result_src(result_src), .busy(busy)
`ifdef HISTO_ARB_STATS_EN
        , .frames0_o(frames0_o), .frames1_o(frames1_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        check({tag, " rx_valid"}, {31'd0, rx_valid}, 32'd0);
        check({tag, " rx_done"}, {31'd0, rx_done}, 32'd0);
        check({tag, " s0_tready"}, {31'd0, s0_tready}, 32'd0);
        check({tag, " s1_tready"}, {31'd0, s1_tready}, 32'd0);
        check({tag, " data"}, {30'd0, histo_data_i}, 32'd0);
    endtask

    // In DRAIN: show the accepted last result bin for one edge, then release.
    task automatic drain(input string tag);
        check({tag, " drain busy"}, {31'd0, busy}, 32'd1);
        histo_data_valid = 1'b1; histo_data_last = 1'b1; tready = 1'b1;
        step();
        histo_data_valid = 1'b0; histo_data_last = 1'b0; tready = 1'b0;
        #1;
        check({tag, " post-drain busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        areset_n = 1'b0;
        s0_tdata = '0; s0_tvalid = 0; s0_tlast = 0;
        s1_tdata = '0; s1_tvalid = 0; s1_tlast = 0;
        histo_ready = 0; histo_data_valid = 0; histo_data_last = 0; tready = 0;
        #3;
        check_idle_outputs("reset");
        check("reset result_src", {31'd0, result_src}, 32'd0);
        step();
        areset_n = 1'b1;

        // T1: four-beat frame from s0
        s0_tvalid = 1; histo_ready = 1;
        #1;
        check("T1 idle s0_tready", {31'd0, s0_tready}, 32'd0);
        check("T1 idle busy", {31'd0, busy}, 32'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            s0_tdata = P_DW'(i); s0_tlast = (i == 3);
            #1;
            check($sformatf("T1 beat%0d rx_valid", i), {31'd0, rx_valid}, 32'd1);
            check($sformatf("T1 beat%0d data", i), {30'd0, histo_data_i}, i);
            check($sformatf("T1 beat%0d s0_tready", i), {31'd0, s0_tready}, 32'd1);
            check($sformatf("T1 beat%0d rx_done", i), {31'd0, rx_done}, 32'd0);
            step();
        end
        s0_tvalid = 0; s0_tlast = 0;
        #1;
        check("T1 done rx_done", {31'd0, rx_done}, 32'd1);
        check("T1 done rx_valid", {31'd0, rx_valid}, 32'd0);
        check("T1 done s0_tready", {31'd0, s0_tready}, 32'd0);
        check("T1 result_src", {31'd0, result_src}, 32'd0);
        step();
        check("T1 drain rx_done", {31'd0, rx_done}, 32'd0);
        check("T1 drain busy", {31'd0, busy}, 32'd1);
        drain("T1");
`ifdef HISTO_ARB_STATS_EN
        check("T1 frames0", {16'd0, frames0_o}, 32'd1);
`endif

        // T2: both valid after reset -> s0, s1, s0
        areset_n = 0; step(); areset_n = 1;
        s0_tvalid = 1; s0_tlast = 1; s0_tdata = 2'd1;
        s1_tvalid = 1; s1_tlast = 1; s1_tdata = 2'd2;
        step();
        check("T2 first src", {31'd0, result_src}, 32'd0);
        check("T2 first s0_tready", {31'd0, s0_tready}, 32'd1);
        check("T2 first s1_tready", {31'd0, s1_tready}, 32'd0);
        check("T2 first data", {30'd0, histo_data_i}, 32'd1);
        step();
        check("T2 first rx_done", {31'd0, rx_done}, 32'd1);
        step();
        drain("T2a");
        step();
        check("T2 second src", {31'd0, result_src}, 32'd1);
        check("T2 second s1_tready", {31'd0, s1_tready}, 32'd1);
        check("T2 second s0_tready", {31'd0, s0_tready}, 32'd0);
        check("T2 second data", {30'd0, histo_data_i}, 32'd2);
        step(); step();
        drain("T2b");
        step();
        check("T2 third src", {31'd0, result_src}, 32'd0);
        check("T2 third s0_tready", {31'd0, s0_tready}, 32'd1);
        s1_tvalid = 0; s1_tlast = 0;
        step();
        s0_tvalid = 0; s0_tlast = 0;
        step();
        drain("T2c");
`ifdef HISTO_ARB_STATS_EN
        check("T2 frames0", {16'd0, frames0_o}, 32'd2);
        check("T2 frames1", {16'd0, frames1_o}, 32'd1);
`endif

        // T3: s1 without tlast closes at P_MAX_BEATS
        s1_tvalid = 1;
        step();
        check("T3 src", {31'd0, result_src}, 32'd1);
        for (int i = 0; i < P_MAX_BEATS; i++) begin
            s1_tdata = P_DW'(i);
            #1;
            check($sformatf("T3 beat%0d rx_valid", i), {31'd0, rx_valid}, 32'd1);
            check($sformatf("T3 beat%0d rx_done", i), {31'd0, rx_done}, 32'd0);
            step();
        end
        check("T3 done rx_done", {31'd0, rx_done}, 32'd1);
        check("T3 done s1_tready", {31'd0, s1_tready}, 32'd0);
        step();
        check("T3 drain s1_tready", {31'd0, s1_tready}, 32'd0);
        s1_tvalid = 0;
        drain("T3");

        // T4: histo_ready stall for 3 cycles mid-frame
        s0_tvalid = 1;
        step();
        check("T4 src", {31'd0, result_src}, 32'd0);
        for (int i = 0; i < P_MAX_BEATS; i++) begin
            s0_tdata = P_DW'(i);
            if (i == 3) begin
                histo_ready = 0;
                for (int k = 0; k < 3; k++) begin
                    #1;
                    check($sformatf("T4 stall%0d s0_tready", k), {31'd0, s0_tready}, 32'd0);
                    check($sformatf("T4 stall%0d data", k), {30'd0, histo_data_i}, 32'd3);
                    step();
                end
                histo_ready = 1;
            end
            #1;
            check($sformatf("T4 beat%0d data", i), {30'd0, histo_data_i}, i % 4);
            check($sformatf("T4 beat%0d rx_done", i), {31'd0, rx_done}, 32'd0);
            step();
        end
        s0_tvalid = 0;
        check("T4 done rx_done", {31'd0, rx_done}, 32'd1);
        step();

        // T5: DRAIN holds while downstream tready is low
        histo_data_valid = 1; histo_data_last = 1; tready = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("T5 hold%0d busy", k), {31'd0, busy}, 32'd1);
        end
        histo_data_last = 0; tready = 1;
        step();
        check("T5 not-last busy", {31'd0, busy}, 32'd1);
        histo_data_valid = 0; histo_data_last = 0; tready = 0;
        drain("T5");
`ifdef HISTO_ARB_STATS_EN
        check("T5 frames0", {16'd0, frames0_o}, 32'd3);
        check("T5 frames1", {16'd0, frames1_o}, 32'd2);
`endif

        // T6: asynchronous reset during STREAM
        s0_tvalid = 1; s0_tdata = 2'd3;
        step();
        check("T6 stream busy", {31'd0, busy}, 32'd1);
        check("T6 stream rx_valid", {31'd0, rx_valid}, 32'd1);
        areset_n = 0;
        #1;
        check_idle_outputs("T6 reset");
        check("T6 reset result_src", {31'd0, result_src}, 32'd0);
`ifdef HISTO_ARB_STATS_EN
        check("T6 frames0", {16'd0, frames0_o}, 32'd0);
        check("T6 frames1", {16'd0, frames1_o}, 32'd0);
`endif
        step();
        check("T6 held busy", {31'd0, busy}, 32'd0);
        areset_n = 1;
        step();
        check("T6 regrant busy", {31'd0, busy}, 32'd1);
        check("T6 regrant src", {31'd0, result_src}, 32'd0);
        s0_tvalid = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
